parity_frame_arbiter: RTL

Shares one 16-bit word parity generator between NUM_REQ requesters. Each requester sends a frame of one or more words over a valid/ready stream with a last flag. The block grants requesters round-robin and holds the grant for a whole frame. It XOR-accumulates per-word parity across the frame and emits one registered result per frame: parity, requester ID and word count. It sits between the packet sources and the integrity/check logic.

---
 rtl/parity_arb_pkg.sv | 23 ++
 rtl/parity_frame_arbiter_parity_gen.sv | 13 +
 rtl/parity_frame_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/parity_arb_pkg.sv
// Shared types and defaults for the parity frame arbiter.
//   state_e : arbiter state (IDLE searching for a requester, LOCK holding one)
//   clog2   : ceil(log2(n)), floored at 1 so a 2-requester ID is still 1 bit
package parity_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int DATA_W_DEFAULT  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_frame_arbiter_parity_gen.sv
// Combinational word parity generator.
//   data_i   : word to reduce
//   parity_o : XOR of all bits of data_i (even parity bit)
module ParityGenerator #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);

    assign parity_o = ^data_i;

endmodule

// File: rtl/parity_frame_arbiter.sv
// Round-robin arbiter sharing one word parity generator between NUM_REQ
// framed valid/ready streams. A grant is held for a whole frame; one
// registered result (parity, owner ID, saturating word count) per frame.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   req_valid_i/last_i/data_i: per-requester word stream (data packed k*DATA_W)
//   req_ready_o              : one-hot (or zero) accept
//   res_*                    : frame result stream, held until res_ready_i
//   busy_o                   : high while a multi-word frame owns the grant
module parity_frame_arbiter
    import parity_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter bit ODD     = 1'b0,
    parameter int LEN_W   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic                        res_parity_o,
    output logic [clog2(NUM_REQ)-1:0]   res_id_o,
    output logic [LEN_W-1:0]            res_len_o,
    output logic                        busy_o
);

    localparam int ID_W = clog2(NUM_REQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic              acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic              res_parity_q, res_parity_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [LEN_W-1:0]  res_len_q, res_len_d;

    logic              can_accept, grant_vld, xfer, word_par, acc_n;
    logic [ID_W-1:0]   grant;
    logic [ID_W:0]     idx;
    logic [DATA_W-1:0] grant_word;
    logic [LEN_W-1:0]  cnt_n;

    // A pending result blocks every word, not only last words, so a frame
    // never runs ahead of an unconsumed result.
    assign can_accept = !res_valid_q || res_ready_i;

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        grant     = lock_id_q;
        grant_vld = 1'b0;
        idx       = '0;
        if (state_q == LOCK) begin
            grant_vld = 1'b1;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
                if (req_valid_i[idx[ID_W-1:0]]) begin
                    grant     = idx[ID_W-1:0];
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_word  = '0;
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == ID_W'(k)) begin
                grant_word     = req_data_i[k*DATA_W +: DATA_W];
                req_ready_o[k] = grant_vld && can_accept;
            end
        end
    end

    ParityGenerator #(.DATA_W(DATA_W)) u_parity (
        .data_i   (grant_word),
        .parity_o (word_par)
    );

    assign xfer  = grant_vld && req_valid_i[grant] && can_accept;
    assign acc_n = acc_q ^ word_par;
    assign cnt_n = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_id_d    = lock_id_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        res_valid_d  = res_valid_q;
        res_parity_d = res_parity_q;
        res_id_d     = res_id_q;
        res_len_d    = res_len_q;

        if (res_valid_q && res_ready_i) res_valid_d = 1'b0;

        if (xfer) begin
            if (!req_last_i[grant]) begin
                acc_d     = acc_n;
                cnt_d     = cnt_n;
                state_d   = LOCK;
                lock_id_d = grant;
            end else begin
                // Overrides the consume above when both happen together.
                res_valid_d  = 1'b1;
                res_parity_d = acc_n ^ ODD;
                res_id_d     = grant;
                res_len_d    = cnt_n;
                acc_d        = 1'b0;
                cnt_d        = '0;
                state_d      = IDLE;
                rr_ptr_d     = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_id_q    <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_parity_q <= 1'b0;
            res_id_q     <= '0;
            res_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_id_q    <= lock_id_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            res_parity_q <= res_parity_d;
            res_id_q     <= res_id_d;
            res_len_q    <= res_len_d;
        end
    end

    assign res_valid_o  = res_valid_q;
    assign res_parity_o = res_parity_q;
    assign res_id_o     = res_id_q;
    assign res_len_o    = res_len_q;
    assign busy_o       = (state_q == LOCK);

endmodule
